// File: rtl/fpdiv_arbiter.sv
// Round-robin share of one fpdiv between two requesters; resp_valid rises the cycle after div_done.
// Requesters stall (req_ready=0) until the resp handshake; define FPDIV_ARB_TIMEOUT_EN for a BUSY watchdog.
module fpdiv_arbiter #(
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT      = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [127:0] req_op1,
  input  logic [127:0] req_op2,
  input  logic [5:0]   req_rm,
  input  logic [1:0]   req_op_type,
  input  logic [1:0]   req_p,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_id,
  output logic [63:0]  resp_result,
  output logic [4:0]   resp_flags,
  output logic         resp_denorm,
  output logic         resp_err,
  output logic         div_start,
  output logic [63:0]  div_op1,
  output logic [63:0]  div_op2,
  output logic [2:0]   div_rm,
  output logic         div_op_type,
  output logic         div_p,
  input  logic         div_done,
  input  logic [63:0]  div_result,
  input  logic [4:0]   div_flags,
  input  logic         div_denorm
);

  typedef enum logic [1:0] {IDLE, START, BUSY, RESP} state_t;

  typedef struct packed {
    logic [63:0] op1;
    logic [63:0] op2;
    logic [2:0]  rm;
    logic        op_type;
    logic        p;
  } op_t;

  localparam int CNT_W = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;
  op_t               op_q, op_d;
  logic              id_q, id_d;
  logic              div_start_q, div_start_d;
  logic              resp_valid_q, resp_valid_d;
  logic [63:0]       resp_result_q, resp_result_d;
  logic [4:0]        resp_flags_q, resp_flags_d;
  logic              resp_denorm_q, resp_denorm_d;

`ifdef FPDIV_ARB_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              resp_err_q, resp_err_d;
`else
  wire               unused_timeout = (TIMEOUT != 0);
`endif

  logic [1:0] grant;
  op_t        sel_op;

  // The requester not served last wins a tie; a lone requester always wins.
  always_comb begin
    grant[0]       = req_valid[0] && (!req_valid[1] || last_q);
    grant[1]       = req_valid[1] && (!req_valid[0] || !last_q);
    sel_op.op1     = grant[1] ? req_op1[127:64] : req_op1[63:0];
    sel_op.op2     = grant[1] ? req_op2[127:64] : req_op2[63:0];
    sel_op.rm      = grant[1] ? req_rm[5:3]     : req_rm[2:0];
    sel_op.op_type = grant[1] ? req_op_type[1]  : req_op_type[0];
    sel_op.p       = grant[1] ? req_p[1]        : req_p[0];
  end

  assign req_ready = (state_q == IDLE && reset) ? grant : 2'b00;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_d        = last_q;
    op_d          = op_q;
    id_d          = id_q;
    div_start_d   = div_start_q;
    resp_valid_d  = resp_valid_q;
    resp_result_d = resp_result_q;
    resp_flags_d  = resp_flags_q;
    resp_denorm_d = resp_denorm_q;
`ifdef FPDIV_ARB_TIMEOUT_EN
    wd_d          = wd_q;
    resp_err_d    = resp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (|grant) begin
          op_d        = sel_op;
          id_d        = grant[1];
          cnt_d       = '0;
          div_start_d = 1'b1;
          state_d     = START;
        end
      end
      START: begin
        // div_done is not looked at here: a done left over from a prior op must not be captured.
`ifdef FPDIV_ARB_TIMEOUT_EN
        wd_d = '0;
`endif
        if (cnt_q == CNT_W'(START_CYCLES - 1)) begin
          div_start_d = 1'b0;
          state_d     = BUSY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BUSY: begin
        if (div_done) begin
          resp_result_d = div_result;
          resp_flags_d  = div_flags;
          resp_denorm_d = div_denorm;
          resp_valid_d  = 1'b1;
          state_d       = RESP;
`ifdef FPDIV_ARB_TIMEOUT_EN
          resp_err_d    = 1'b0;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          resp_result_d = '0;
          resp_flags_d  = '0;
          resp_denorm_d = 1'b0;
          resp_err_d    = 1'b1;
          resp_valid_d  = 1'b1;
          state_d       = RESP;
        end else begin
          wd_d = wd_q + 1'b1;
`endif
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          last_d       = id_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      last_q        <= 1'b1;
      op_q          <= '0;
      id_q          <= 1'b0;
      div_start_q   <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_result_q <= '0;
      resp_flags_q  <= '0;
      resp_denorm_q <= 1'b0;
`ifdef FPDIV_ARB_TIMEOUT_EN
      wd_q          <= '0;
      resp_err_q    <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_q        <= last_d;
      op_q          <= op_d;
      id_q          <= id_d;
      div_start_q   <= div_start_d;
      resp_valid_q  <= resp_valid_d;
      resp_result_q <= resp_result_d;
      resp_flags_q  <= resp_flags_d;
      resp_denorm_q <= resp_denorm_d;
`ifdef FPDIV_ARB_TIMEOUT_EN
      wd_q          <= wd_d;
      resp_err_q    <= resp_err_d;
`endif
    end
  end

`ifdef FPDIV_ARB_TIMEOUT_EN
  assign resp_err    = resp_err_q;
`else
  assign resp_err    = 1'b0;
`endif
  assign resp_valid  = resp_valid_q;
  assign resp_id     = id_q;
  assign resp_result = resp_result_q;
  assign resp_flags  = resp_flags_q;
  assign resp_denorm = resp_denorm_q;
  assign div_start   = div_start_q;
  assign div_op1     = op_q.op1;
  assign div_op2     = op_q.op2;
  assign div_rm      = op_q.rm;
  assign div_op_type = op_q.op_type;
  assign div_p       = op_q.p;

endmodule

// File: tb/tb_fpdiv_arbiter.sv
// Directed bench for fpdiv_arbiter; the bench plays the shared fpdiv with fixed, hand-computed quotients.
module tb_fpdiv_arbiter;

  localparam logic [63:0] OP1_0 = 64'h3F80_0000_0000_0000;  // 2^-7
  localparam logic [63:0] OP2_0 = 64'h4000_0000_0000_0000;  // 2.0
  localparam logic [63:0] RES_0 = 64'h3F70_0000_0000_0000;  // 2^-8
  localparam logic [63:0] OP1_1 = 64'h4010_0000_0000_0000;  // 4.0
  localparam logic [63:0] OP2_1 = 64'h3FF0_0000_0000_0000;  // 1.0
  localparam logic [63:0] RES_1 = 64'h4010_0000_0000_0000;  // 4.0
  localparam logic [63:0] BAD   = 64'hDEAD_BEEF_DEAD_BEEF;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [127:0] req_op1, req_op2;
  logic [5:0]   req_rm;
  logic [1:0]   req_op_type, req_p;
  logic         resp_valid, resp_ready, resp_id;
  logic [63:0]  resp_result;
  logic [4:0]   resp_flags;
  logic         resp_denorm, resp_err;
  logic         div_start;
  logic [63:0]  div_op1, div_op2;
  logic [2:0]   div_rm;
  logic         div_op_type, div_p;
  logic         div_done;
  logic [63:0]  div_result;
  logic [4:0]   div_flags;
  logic         div_denorm;

  int checks = 0;
  int errors = 0;
  int len;
  int n;

  always #5 clk = ~clk;

  fpdiv_arbiter dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2), .req_rm(req_rm),
    .req_op_type(req_op_type), .req_p(req_p),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_flags(resp_flags),
    .resp_denorm(resp_denorm), .resp_err(resp_err),
    .div_start(div_start), .div_op1(div_op1), .div_op2(div_op2),
    .div_rm(div_rm), .div_op_type(div_op_type), .div_p(div_p),
    .div_done(div_done), .div_result(div_result),
    .div_flags(div_flags), .div_denorm(div_denorm)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after the accept edge: measures div_start width, then returns done after dly BUSY cycles.
  task automatic serve(input logic [63:0] res, input logic [4:0] flg, input logic dn,
                       input int dly, output int start_len);
    start_len = 0;
    while (div_start && start_len < 20) begin
      start_len++;
      tick();
    end
    repeat (dly - 1) tick();
    chk("busy_no_resp", 64'(resp_valid), 64'd0);
    div_done   = 1'b1;
    div_result = res;
    div_flags  = flg;
    div_denorm = dn;
    tick();
    div_done   = 1'b0;
    div_result = BAD;
  endtask

  task automatic handshake();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("resp_drop", 64'(resp_valid), 64'd0);
  endtask

  initial begin
    reset       = 1'b0;
    req_valid   = 2'b00;
    req_op1     = {OP1_1, OP1_0};
    req_op2     = {OP2_1, OP2_0};
    req_rm      = {3'b001, 3'b010};
    req_op_type = 2'b10;
    req_p       = 2'b10;
    resp_ready  = 1'b0;
    div_done    = 1'b0;
    div_result  = BAD;
    div_flags   = 5'h1F;
    div_denorm  = 1'b0;
    tick();
    tick();

    // Reset state, with both requests pending to show req_ready is held low.
    req_valid = 2'b11;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_div_start", 64'(div_start), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_id", 64'(resp_id), 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    chk("rst_resp_result", resp_result, 64'd0);
    chk("rst_resp_flags", 64'(resp_flags), 64'd0);
    chk("rst_resp_denorm", 64'(resp_denorm), 64'd0);
    chk("rst_div_op1", div_op1, 64'd0);
    chk("rst_div_op2", div_op2, 64'd0);
    chk("rst_div_rm", 64'(div_rm), 64'd0);
    req_valid = 2'b00;
    reset     = 1'b1;
    tick();

    // Single request from requester 0.
    req_valid = 2'b01;
    #1;
    chk("t1_ready", 64'(req_ready), 64'd1);
    tick();
    req_valid = 2'b00;
    chk("t1_div_start", 64'(div_start), 64'd1);
    chk("t1_div_op1", div_op1, OP1_0);
    chk("t1_div_op2", div_op2, OP2_0);
    chk("t1_div_rm", 64'(div_rm), 64'd2);
    chk("t1_div_op_type", 64'(div_op_type), 64'd0);
    chk("t1_div_p", 64'(div_p), 64'd0);
    chk("t1_ready_start", 64'(req_ready), 64'd0);
    serve(RES_0, 5'h01, 1'b0, 10, len);
    chk("t1_start_len", 64'(len), 64'd2);
    chk("t1_resp_valid", 64'(resp_valid), 64'd1);
    chk("t1_resp_id", 64'(resp_id), 64'd0);
    chk("t1_resp_result", resp_result, RES_0);
    chk("t1_resp_flags", 64'(resp_flags), 64'd1);
    chk("t1_resp_err", 64'(resp_err), 64'd0);
    handshake();

    // Round robin from a fresh reset with both requesters always valid.
    reset = 1'b0;
    tick();
    reset     = 1'b1;
    req_valid = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("rr_ready", 64'(req_ready), (k % 2 == 1) ? 64'd2 : 64'd1);
      tick();
      chk("rr_div_op1", div_op1, (k % 2 == 1) ? OP1_1 : OP1_0);
      chk("rr_div_rm", 64'(div_rm), (k % 2 == 1) ? 64'd1 : 64'd2);
      chk("rr_div_op_type", 64'(div_op_type), (k % 2 == 1) ? 64'd1 : 64'd0);
      serve((k % 2 == 1) ? RES_1 : RES_0, 5'(k + 2), 1'(k % 2), 3 + k, len);
      chk("rr_start_len", 64'(len), 64'd2);
      if (k == 2) begin
        repeat (5) begin
          chk("bp_resp_valid", 64'(resp_valid), 64'd1);
          chk("bp_resp_result", resp_result, RES_0);
          chk("bp_resp_flags", 64'(resp_flags), 64'd4);
          chk("bp_resp_id", 64'(resp_id), 64'd0);
          chk("bp_req_ready", 64'(req_ready), 64'd0);
          tick();
        end
      end
      chk("rr_resp_id", 64'(resp_id), (k % 2 == 1) ? 64'd1 : 64'd0);
      chk("rr_resp_result", resp_result, (k % 2 == 1) ? RES_1 : RES_0);
      chk("rr_resp_denorm", 64'(resp_denorm), 64'(k % 2));
      chk("rr_ready_resp", 64'(req_ready), 64'd0);
      handshake();
    end
    req_valid = 2'b00;

    // Stale done during START must not be captured.
    req_valid = 2'b01;
    #1;
    chk("st_ready", 64'(req_ready), 64'd1);
    tick();
    req_valid  = 2'b00;
    div_done   = 1'b1;
    div_result = BAD;
    tick();
    tick();
    div_done = 1'b0;
    chk("st_start_low", 64'(div_start), 64'd0);
    chk("st_no_resp", 64'(resp_valid), 64'd0);
    repeat (3) tick();
    chk("st_no_resp_later", 64'(resp_valid), 64'd0);
    div_done   = 1'b1;
    div_result = RES_0;
    div_flags  = 5'h00;
    tick();
    div_done   = 1'b0;
    chk("st_resp_valid", 64'(resp_valid), 64'd1);
    chk("st_resp_result", resp_result, RES_0);
    handshake();

    // Reset pulse in BUSY aborts requester 1's op.
    req_valid = 2'b10;
    #1;
    chk("rb_ready", 64'(req_ready), 64'd2);
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    chk("rb_busy_op1", div_op1, OP1_1);
    reset = 1'b0;
    tick();
    chk("rb_div_start", 64'(div_start), 64'd0);
    chk("rb_resp_valid", 64'(resp_valid), 64'd0);
    chk("rb_div_op1", div_op1, 64'd0);
    chk("rb_div_op2", div_op2, 64'd0);
    chk("rb_resp_id", 64'(resp_id), 64'd0);
    chk("rb_resp_result", resp_result, 64'd0);
    reset      = 1'b1;
    div_done   = 1'b1;
    div_result = BAD;
    tick();
    div_done = 1'b0;
    tick();
    chk("rb_no_resp", 64'(resp_valid), 64'd0);
    req_valid = 2'b11;
    #1;
    chk("rb_ready_after", 64'(req_ready), 64'd1);
    tick();
    req_valid = 2'b00;
    serve(RES_0, 5'h03, 1'b0, 4, len);
    chk("rb_start_len", 64'(len), 64'd2);
    chk("rb_resp_valid2", 64'(resp_valid), 64'd1);
    chk("rb_resp_id2", 64'(resp_id), 64'd0);
    chk("rb_resp_result2", resp_result, RES_0);
    chk("rb_resp_flags2", 64'(resp_flags), 64'd3);
    handshake();

    // div_done never arrives.
    req_valid = 2'b01;
    #1;
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    chk("to_start_low", 64'(div_start), 64'd0);
`ifdef FPDIV_ARB_TIMEOUT_EN
    n = 0;
    while (!resp_valid && n < 100) begin
      tick();
      n++;
    end
    chk("to_cycles", 64'(n), 64'd64);
    chk("to_resp_err", 64'(resp_err), 64'd1);
    chk("to_resp_result", resp_result, 64'd0);
    chk("to_resp_flags", 64'(resp_flags), 64'd0);
    handshake();
`else
    repeat (80) tick();
    chk("to_no_resp", 64'(resp_valid), 64'd0);
    chk("to_resp_err", 64'(resp_err), 64'd0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
